// File: rtl/iomem_gpio_pkg.sv
// rtl/iomem_gpio_pkg.sv - register map and byte-lane helper shared by the iomem_gpio slice
package iomem_gpio_pkg;

  localparam int NUM_REGS = 8;
  localparam int OFF_W    = 3;

  typedef enum logic [OFF_W-1:0] {
    REG_OUT     = 3'd0,
    REG_OE      = 3'd1,
    REG_IN      = 3'd2,
    REG_RISE_EN = 3'd3,
    REG_FALL_EN = 3'd4,
    REG_IRQ_EN  = 3'd5,
    REG_STATUS  = 3'd6,
    REG_RSVD    = 3'd7
  } reg_off_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - one pin: multi-flop input synchroniser plus enabled edge detector
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  input  logic i_rise_en,
  input  logic i_fall_en,
  input  logic i_arm,
  output logic o_sync,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_rise;
  logic                   w_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = i_rise_en &  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_fall = i_fall_en & ~r_sync[SYNC_STAGES-1] &  r_prev;
  // i_arm masks the false transition seen while the chain refills after reset
  assign o_edge = i_arm & (w_rise | w_fall);

endmodule

// File: rtl/iomem_gpio.sv
// rtl/iomem_gpio.sv - GPIO block on the PicoRV32-style iomem bus with edge-triggered interrupts
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int         NUM_PINS    = 32,
  parameter logic [7:0] BASE_PAGE   = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic                r_ready;
  logic [31:0]         r_rdata;
  logic                r_irq;
  logic [2:0]          r_arm_cnt;
  logic [NUM_PINS-1:0] r_out;
  logic [NUM_PINS-1:0] r_oe;
  logic [NUM_PINS-1:0] r_rise_en;
  logic [NUM_PINS-1:0] r_fall_en;
  logic [NUM_PINS-1:0] r_irq_en;
  logic [NUM_PINS-1:0] r_status;

  logic                w_hit;
  logic                w_wr;
  logic                w_armed;
  reg_off_e            w_offset;
  logic [31:0]         w_lane_mask;
  logic [NUM_PINS-1:0] w_wmask;
  logic [NUM_PINS-1:0] w_wdata;
  logic [NUM_PINS-1:0] w_w1c;
  logic [NUM_PINS-1:0] w_sync;
  logic [NUM_PINS-1:0] w_edge;
  logic [NUM_PINS-1:0] w_rd_pins;
  logic [31:0]         w_rd_data;
  logic                w_unused;

  assign w_hit       = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_PAGE);
  assign w_wr        = w_hit && (iomem_wstrb != 4'b0000);
  assign w_offset    = reg_off_e'(iomem_addr[4:2]);
  assign w_lane_mask = lane_mask(iomem_wstrb);
  assign w_wmask     = w_lane_mask[NUM_PINS-1:0];
  assign w_wdata     = iomem_wdata[NUM_PINS-1:0];
  assign w_w1c       = (w_wr && (w_offset == REG_STATUS)) ? (w_wdata & w_wmask) : '0;
  assign w_armed     = (r_arm_cnt == ARM_CYCLES);
  assign w_unused    = &{1'b0, iomem_addr[23:5], iomem_addr[1:0], w_lane_mask, iomem_wdata};

  function automatic logic [NUM_PINS-1:0] merge(input logic [NUM_PINS-1:0] old_val);
    return (old_val & ~w_wmask) | (w_wdata & w_wmask);
  endfunction

  genvar g;
  for (g = 0; g < NUM_PINS; g++) begin : g_pin
    gpio_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
      .clk       (clk),
      .reset     (reset),
      .i_pin     (gpio_in[g]),
      .i_rise_en (r_rise_en[g]),
      .i_fall_en (r_fall_en[g]),
      .i_arm     (w_armed),
      .o_sync    (w_sync[g]),
      .o_edge    (w_edge[g])
    );
  end

  always_comb begin
    w_rd_pins = '0;
    case (w_offset)
      REG_OUT:     w_rd_pins = r_out;
      REG_OE:      w_rd_pins = r_oe;
      REG_IN:      w_rd_pins = w_sync;
      REG_RISE_EN: w_rd_pins = r_rise_en;
      REG_FALL_EN: w_rd_pins = r_fall_en;
      REG_IRQ_EN:  w_rd_pins = r_irq_en;
      REG_STATUS:  w_rd_pins = r_status;
      default:     w_rd_pins = '0;
    endcase
    w_rd_data = '0;
    w_rd_data[NUM_PINS-1:0] = w_rd_pins;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_irq     <= 1'b0;
      r_arm_cnt <= '0;
      r_out     <= '0;
      r_oe      <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_irq_en  <= '0;
      r_status  <= '0;
    end else begin
      r_ready <= w_hit;
      // rdata is taken from the pre-write register values
      r_rdata <= w_hit ? w_rd_data : '0;
      if (w_wr) begin
        case (w_offset)
          REG_OUT:     r_out     <= merge(r_out);
          REG_OE:      r_oe      <= merge(r_oe);
          REG_RISE_EN: r_rise_en <= merge(r_rise_en);
          REG_FALL_EN: r_fall_en <= merge(r_fall_en);
          REG_IRQ_EN:  r_irq_en  <= merge(r_irq_en);
          default:     ;
        endcase
      end
      // a new edge wins over a same-cycle write-1-to-clear
      r_status <= (r_status & ~w_w1c) | w_edge;
      r_irq    <= |(r_status & r_irq_en);
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + 3'd1;
      end
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign gpio_out    = r_out;
  assign gpio_oe     = r_oe;
  assign irq         = r_irq;

endmodule

// File: tb/tb_iomem_gpio.sv
// tb/tb_iomem_gpio.sv - directed self-checking bench for iomem_gpio with 16 pins
module tb_iomem_gpio;

  logic        clk;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  int n_vec  = 0;
  int n_fail = 0;

  iomem_gpio #(
    .NUM_PINS    (16),
    .BASE_PAGE   (8'h03),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, output logic [31:0] rdata);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wdata = wdata;
    iomem_wstrb = wstrb;
    @(posedge clk);
    #1;
    check({tag, " ready"}, {31'b0, iomem_ready}, 32'd1);
    rdata       = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    @(posedge clk);
    #1;
    check({tag, " ready one cycle"}, {31'b0, iomem_ready}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        seen;

  initial begin
    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = '0;
    iomem_wdata = '0;
    gpio_in     = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset gpio_out", {16'b0, gpio_out}, 32'h0);
    check("reset gpio_oe", {16'b0, gpio_oe}, 32'h0);
    check("reset irq", {31'b0, irq}, 32'h0);
    check("reset ready", {31'b0, iomem_ready}, 32'h0);
    check("reset rdata", iomem_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // OUT write with lanes 0-1 only, then readback
    bus("out wr", 32'h0300_0000, 32'h0003_A5A5, 4'b0011, rd);
    check("gpio_out A5A5", {16'b0, gpio_out}, 32'h0000_A5A5);
    bus("out rd", 32'h0300_0000, 32'h0, 4'b0000, rd);
    check("out readback", rd, 32'h0000_A5A5);

    // bits above NUM_PINS read as zero
    bus("fall wr all", 32'h0300_0010, 32'hFFFF_FFFF, 4'b1111, rd);
    bus("fall rd", 32'h0300_0010, 32'h0, 4'b0000, rd);
    check("fall_en upper bits masked", rd, 32'h0000_FFFF);
    bus("fall clr", 32'h0300_0010, 32'h0, 4'b1111, rd);

    // OE per byte lane
    bus("oe lane0", 32'h0300_0004, 32'h0000_00FF, 4'b0001, rd);
    check("gpio_oe 00FF", {16'b0, gpio_oe}, 32'h0000_00FF);
    bus("oe lane1", 32'h0300_0004, 32'h0000_FF00, 4'b0010, rd);
    check("gpio_oe FFFF", {16'b0, gpio_oe}, 32'h0000_FFFF);

    // rising edge on pin 0 raises STATUS then irq
    bus("rise_en wr", 32'h0300_000C, 32'h0000_0001, 4'b0001, rd);
    bus("irq_en wr", 32'h0300_0014, 32'h0000_0001, 4'b0001, rd);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    @(posedge clk); #1;
    check("irq edge+1", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq edge+2", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq edge+3", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq edge+4", {31'b0, irq}, 32'd1);
    bus("status rd", 32'h0300_0018, 32'h0, 4'b0000, rd);
    check("status after rise", rd, 32'h0000_0001);
    bus("in rd", 32'h0300_0008, 32'h0, 4'b0000, rd);
    check("in reads pin0", rd, 32'h0000_0001);
    bus("status w1c", 32'h0300_0018, 32'h0000_0001, 4'b0001, rd);
    check("irq after w1c", {31'b0, irq}, 32'd0);
    bus("status rd2", 32'h0300_0018, 32'h0, 4'b0000, rd);
    check("status cleared", rd, 32'h0);

    // falling edge on pin 3 coinciding with W1C of bit 3
    bus("fall_en wr", 32'h0300_0010, 32'h0000_0008, 4'b0001, rd);
    @(negedge clk);
    gpio_in[3] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    gpio_in[3] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    bus("status w1c collide", 32'h0300_0018, 32'h0000_0008, 4'b0001, rd);
    bus("status rd3", 32'h0300_0018, 32'h0, 4'b0000, rd);
    check("status set wins over w1c", rd, 32'h0000_0008);
    check("irq masked pin3", {31'b0, irq}, 32'd0);

    // foreign page gets no ready; offset 7 and IN ignore writes
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0000;
    iomem_wstrb = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) seen = 1'b1;
    end
    iomem_valid = 1'b0;
    check("foreign page no ready", {31'b0, seen}, 32'd0);
    bus("rsvd wr", 32'h0300_001C, 32'hFFFF_FFFF, 4'b1111, rd);
    bus("rsvd rd", 32'h0300_001C, 32'h0, 4'b0000, rd);
    check("rsvd reads zero", rd, 32'h0);
    bus("in wr", 32'h0300_0008, 32'h0000_FFFF, 4'b0011, rd);
    bus("in rd2", 32'h0300_0008, 32'h0, 4'b0000, rd);
    check("in write ignored", rd, 32'h0000_0001);

    // read data reflects the value before a coinciding write
    bus("out rbw", 32'h0300_0000, 32'h0000_1234, 4'b1111, rd);
    check("read before write", rd, 32'h0000_A5A5);
    check("gpio_out 1234", {16'b0, gpio_out}, 32'h0000_1234);

    // reset in the middle of an access
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0000;
    iomem_wstrb = 4'b0000;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check("no ready after abort", {31'b0, iomem_ready}, 32'd0);
    check("async clear gpio_out", {16'b0, gpio_out}, 32'h0);
    iomem_valid = 1'b0;
    gpio_in = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // enables land before the refilled chain could fake an edge
    bus("post rst rise_en", 32'h0300_000C, 32'h0000_FFFF, 4'b0011, rd);
    bus("post rst irq_en", 32'h0300_0014, 32'h0000_FFFF, 4'b0011, rd);
    check("post rst gpio_oe", {16'b0, gpio_oe}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("no spurious irq c%0d", i), {31'b0, irq}, 32'd0);
    end
    bus("post rst status", 32'h0300_0018, 32'h0, 4'b0000, rd);
    check("no spurious status", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/iomem_gpio.md
IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 SHALL have parameter NUM_PINS, default 32, number of GPIO pins (legal 1..32).
REQ-002 SHALL have parameter BASE_PAGE, default 8'h03, the value of iomem_addr[31:24] that selects this block.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, number of input synchroniser flops (legal 2..4).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1; one clock, reset asynchronous and active-high.
REQ-006 SHALL have port iomem_valid, input, 1, bus request.
REQ-007 SHALL have port iomem_ready, output, 1, one-cycle acknowledge.
REQ-008 SHALL have port iomem_wstrb, input, 4, byte write strobes; 0 means read.
REQ-009 SHALL have port iomem_addr, input, 32, byte address.
REQ-010 SHALL have port iomem_wdata, input, 32, write data.
REQ-011 SHALL have port iomem_rdata, output, 32, read data, valid while iomem_ready=1.
REQ-012 SHALL have port gpio_in, input, NUM_PINS, asynchronous pad inputs.
REQ-013 SHALL have port gpio_out, output, NUM_PINS, pad output data.
REQ-014 SHALL have port gpio_oe, output, NUM_PINS, pad output enables (1 = drive).
REQ-015 SHALL have port irq, output, 1, level interrupt.

Function
REQ-016 SHALL decode a hit as iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_PAGE; register offset = iomem_addr[4:2].
REQ-017 SHALL assert iomem_ready for exactly one cycle, the cycle after a hit; no ready for non-hits.
REQ-018 SHALL provide registers: 0 OUT (rw), 1 OE (rw), 2 IN (ro), 3 RISE_EN (rw), 4 FALL_EN (rw), 5 IRQ_EN (rw), 6 STATUS (read, write-1-to-clear).
REQ-019 SHALL apply writes per byte lane under iomem_wstrb[3:0], in the hit cycle.
REQ-020 SHALL read 0 from offset 7 and ignore writes to it and to IN, still acknowledging.
REQ-021 SHALL read bits >= NUM_PINS as 0 in every register and ignore writes to them.
REQ-022 SHALL drive gpio_out=OUT and gpio_oe=OE directly from registers.
REQ-023 SHALL pass gpio_in through SYNC_STAGES flops; IN reads the last synchroniser stage.
REQ-024 SHALL detect rising edge on pin i when sync[i] goes 0->1 and RISE_EN[i]=1, falling when 1->0 and FALL_EN[i]=1; a detection sets STATUS[i] one cycle later.
REQ-025 SHALL give set priority: edge detection and W1C to the same STATUS bit in the same cycle leaves the bit 1.
REQ-026 SHALL set STATUS independent of IRQ_EN; irq = |(STATUS & IRQ_EN), registered, one cycle after STATUS changes.
REQ-027 SHALL capture iomem_rdata from pre-write register values when a read and write coincide (read-before-write).

Reset
REQ-028 SHALL, on reset, clear OUT, OE, RISE_EN, FALL_EN, IRQ_EN, STATUS, synchroniser flops, iomem_ready, iomem_rdata and irq to 0, immediately and asynchronously.
REQ-029 SHALL generate no spurious edge after reset release: edge detection is suppressed until the synchroniser has held reset-free data for SYNC_STAGES+1 cycles.
REQ-030 SHALL abort an in-flight access if reset asserts mid-transaction; no ready is issued for it.

Structure
REQ-031 SHALL place register offset constants and the register count in package iomem_gpio_pkg.
REQ-032 SHALL implement the synchroniser and edge detector per pin in sub-module gpio_sync_edge, instantiated NUM_PINS times.

Verification
REQ-033 SHALL test: NUM_PINS=16, write 0x0003_A5A5 wstrb=4'b0011 to 0x0300_0000 -> gpio_out=0xA5A5, readback 0x0000_A5A5, ready exactly one cycle.
REQ-034 SHALL test: write OE=0x00FF with wstrb=4'b0001, then 4'b0010 with 0xFF00 -> gpio_oe=0x00FF then 0xFFFF.
REQ-035 SHALL test: RISE_EN=0x0001, IRQ_EN=0x0001, gpio_in[0] 0->1 -> STATUS=0x0001 after SYNC_STAGES+1 cycles, irq=1 one cycle later; W1C 0x0001 -> irq=0.
REQ-036 SHALL test: falling edge on pin 3 with FALL_EN[3]=1 coinciding with W1C of bit 3 -> STATUS[3] stays 1.
REQ-037 SHALL test: access to 0x0400_0000 and offset 0x1C -> no ready for the former, ready with rdata 0 for the latter.
REQ-038 SHALL test: reset asserted with gpio_in=0xFFFF, released -> STATUS stays 0 and irq=0 for 10 cycles.
